clk_div_array: RTL and testbench

Multi-channel programmable clock divider for the mic array front end. It generates CHANNELS independent divided clocks from `clk`, each with a runtime-loadable half-period and phase offset. Ratio changes take effect glitch-free at the next period boundary. A common `sync_in` realigns all channels so that sampling clocks for different mic banks start coherently.

---
 rtl/clk_div_array.sv | 113 +++++++++++
 tb/tb_clk_div_array.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_array.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_array
// Brief    : Multi-channel programmable clock divider with shadowed half-period
//            and phase, glitch-free ratio update and common realign pulse.
//            Define CLK_DIV_ARRAY_ODD_EN to enable odd ratios (2D+1).
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_array #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 6
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [CHANNELS-1:0]                                 en,
    input  logic                                                sync_in,
    input  logic                                                load,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  load_ch,
    input  logic [WIDTH-1:0]                                    load_div,
    input  logic [WIDTH-1:0]                                    load_phase,
    input  logic                                                load_odd,
    output logic [CHANNELS-1:0]                                 clk_out,
    output logic [CHANNELS-1:0]                                 tick
);

    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic w_load_ok;
    logic w_odd_in;

    assign w_load_ok = load && (32'(load_ch) < 32'(CHANNELS));

`ifdef CLK_DIV_ARRAY_ODD_EN
    assign w_odd_in = load_odd;
`else
    logic w_unused_odd;
    assign w_unused_odd = load_odd;
    assign w_odd_in     = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_ds;
        logic [WIDTH-1:0] r_ps;
        logic             r_os;
        logic [WIDTH-1:0] r_da;
        logic             r_oa;
        logic [WIDTH-1:0] r_cnt;
        logic             r_out;
        logic             r_tick;

        logic             w_wr;
        logic [WIDTH-1:0] w_ds_nx;
        logic [WIDTH-1:0] w_ps_nx;
        logic             w_os_nx;
        logic [WIDTH-1:0] w_term;

        // Shadow write-through: a load in this cycle is what any copy sees.
        assign w_wr    = w_load_ok && (load_ch == c_ch_w'(i));
        assign w_ds_nx = w_wr ? load_div   : r_ds;
        assign w_ps_nx = w_wr ? load_phase : r_ps;
        assign w_os_nx = w_wr ? w_odd_in   : r_os;

        // Low half is stretched by the odd bit; only meaningful when r_da != 0.
        assign w_term = r_da - WIDTH'(1)
                      + (r_out ? {WIDTH{1'b0}} : {{(WIDTH-1){1'b0}}, r_oa});

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_ds   <= WIDTH'(RESET_DIV);
                r_ps   <= '0;
                r_os   <= 1'b0;
                r_da   <= WIDTH'(RESET_DIV);
                r_oa   <= 1'b0;
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_ds   <= w_ds_nx;
                r_ps   <= w_ps_nx;
                r_os   <= w_os_nx;
                r_tick <= 1'b0;
                if (!en[i] || sync_in) begin
                    r_da  <= w_ds_nx;
                    r_oa  <= w_os_nx;
                    r_cnt <= w_ps_nx;
                    r_out <= 1'b0;
                end else if (r_da == '0) begin
                    r_da  <= w_ds_nx;
                    r_oa  <= w_os_nx;
                    r_cnt <= '0;
                    r_out <= 1'b0;
                end else if (r_cnt >= w_term) begin
                    r_cnt <= '0;
                    r_out <= ~r_out;
                    // Rising toggle is the period boundary: adopt new ratio here.
                    if (!r_out) begin
                        r_da   <= w_ds_nx;
                        r_oa   <= w_os_nx;
                        r_tick <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end

        assign clk_out[i] = r_out;
        assign tick[i]    = r_tick;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_array.sv
`default_nettype none
// Testbench for clk_div_array: randomized and directed stimulus against a
// count-down behavioural model, checked through an expected-output queue.
module tb_clk_div_array;
    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] en = '0;
    logic          sync_in = 1'b0;
    logic          load = 1'b0;
    logic [1:0]    load_ch = '0;
    logic [W-1:0]  load_div = '0;
    logic [W-1:0]  load_phase = '0;
    logic          load_odd = 1'b0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    clk_div_array #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(6)) dut (
        .clk(clk), .reset(reset), .en(en), .sync_in(sync_in), .load(load),
        .load_ch(load_ch), .load_div(load_div), .load_phase(load_phase),
        .load_odd(load_odd), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] o;
        logic [CH-1:0] t;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_tick[CH];
    int intv[CH];

    // Model state: shadow/active values plus cycles remaining in current half.
    int            m_ds[CH], m_ps[CH], m_os[CH], m_da[CH], m_oa[CH], m_rem[CH];
    logic [CH-1:0] m_out, m_tick;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ds[i] = 6; m_ps[i] = 0; m_os[i] = 0;
            m_da[i] = 6; m_oa[i] = 0; m_rem[i] = 6;
        end
        m_out  = '0;
        m_tick = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            int ds_n, ps_n, os_n;
            ds_n = m_ds[i]; ps_n = m_ps[i]; os_n = m_os[i];
            if (load && int'(load_ch) == i) begin
                ds_n = int'(load_div);
                ps_n = int'(load_phase);
`ifdef CLK_DIV_ARRAY_ODD_EN
                os_n = int'(load_odd);
`else
                os_n = 0;
`endif
            end
            m_tick[i] = 1'b0;
            if (!en[i] || sync_in) begin
                m_da[i] = ds_n; m_oa[i] = os_n; m_out[i] = 1'b0;
                m_rem[i] = max1(m_da[i] + m_oa[i] - ps_n);
            end else if (m_da[i] == 0) begin
                m_da[i] = ds_n; m_oa[i] = os_n; m_out[i] = 1'b0;
                m_rem[i] = m_da[i] + m_oa[i];
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    if (!m_out[i]) begin
                        m_out[i] = 1'b1; m_tick[i] = 1'b1;
                        m_da[i] = ds_n; m_oa[i] = os_n;
                        m_rem[i] = m_da[i];
                    end else begin
                        m_out[i] = 1'b0;
                        m_rem[i] = m_da[i] + m_oa[i];
                    end
                end
            end
            m_ds[i] = ds_n; m_ps[i] = ps_n; m_os[i] = os_n;
        end
    endtask

    task automatic step(input logic [CH-1:0] e, input logic s, input logic l,
                        input int lc, input int ld, input int lp,
                        input logic lo, input logic r);
        @(negedge clk);
        reset = r; en = e; sync_in = s; load = l; load_ch = 2'(lc);
        load_div = W'(ld); load_phase = W'(lp); load_odd = lo;
        if (r) model_reset();
        else   model_step();
        sb_q.push_back({m_out, m_tick});
    endtask

    task automatic idle(input int n);
        repeat (n) step(en, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: pops one expected output per clock and records tick spacing.
    exp_t e_cur;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() > 0) begin
            e_cur = sb_q.pop_front();
            n_tests++;
            if (clk_out !== e_cur.o || tick !== e_cur.t) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL sb cyc %0d: clk_out=%b expected %b, tick=%b expected %b",
                             cyc, clk_out, e_cur.o, tick, e_cur.t);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (tick[i] === 1'b1) begin
                intv[i] = cyc - last_tick[i];
                last_tick[i] = cyc;
            end
        end
    end

    initial begin
        int t0, wait_n;
        logic [CH-1:0] e;
        for (int i = 0; i < CH; i++) begin last_tick[i] = -1000; intv[i] = 0; end
        model_reset();

        // Reset state, then default divide-by-12 on channel 0
        step('0, 0, 0, 0, 0, 0, 0, 1);
        step('0, 0, 0, 0, 0, 0, 0, 1);
        step('0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_clk_out", int'(clk_out), 0);
        step(4'b0001, 0, 0, 0, 0, 0, 0, 0);
        idle(40);
        check("t1_period12", intv[0], 12);
        check("t1_others_silent", int'(last_tick[1] + last_tick[2] + last_tick[3]), -3000);

        // Ratio change mid-high-phase takes effect at the boundary
        wait_n = 0;
        while (clk_out[0] !== 1'b1 && wait_n < 20) begin idle(1); wait_n++; end
        check("t2_reach_high", int'(clk_out[0]), 1);
        idle(2);
        step(en, 0, 1, 0, 3, 0, 0, 0);
        idle(30);
        check("t2_period6", intv[0], 6);

        // Phase offset between two channels after realign
        step('0, 0, 1, 0, 4, 0, 0, 0);
        step('0, 0, 1, 1, 4, 2, 0, 0);
        step(4'b0011, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(en, 1, 0, 0, 0, 0, 0, 0);
        idle(30);
        check("t3_period_ch0", intv[0], 8);
        check("t3_period_ch1", intv[1], 8);
        check("t3_ch1_leads", (((last_tick[0] - last_tick[1]) % 8) + 8) % 8, 2);

        // Load and sync together: new ratio used immediately
        step(en, 1, 1, 0, 5, 0, 0, 0);
        idle(35);
        check("t4_period10", intv[0], 10);

        // D=0 parks the channel; D=2 revives it
        step(en, 0, 1, 0, 0, 0, 0, 0);
        idle(30);
        t0 = last_tick[0];
        idle(30);
        check("t5_no_ticks", last_tick[0], t0);
        check("t5_held_low", int'(clk_out[0]), 0);
        step(en, 0, 1, 0, 2, 0, 0, 0);
        idle(20);
        check("t5_period4", intv[0], 4);

        // Odd-ratio request
        step(4'b0100, 0, 1, 2, 3, 0, 1, 0);
        idle(30);
`ifdef CLK_DIV_ARRAY_ODD_EN
        check("t6_period_odd", intv[2], 7);
`else
        check("t6_period_even", intv[2], 6);
`endif

        // Mid-operation reset, then randomized traffic
        step(4'b1111, 0, 0, 0, 0, 0, 0, 1);
        step(4'b1111, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2500; k++) begin
            e = en;
            if ($urandom_range(0, 29) == 0) e[$urandom_range(0, CH-1)] ^= 1'b1;
            step(e, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 399) == 0);
        end

        idle(2);
        @(posedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
